// File: rtl/dpram_rd_arbiter_if.sv
// Request/response bundle between the read-port arbiter, its requesters and the dpram read port.
interface dpram_rd_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
    logic [NUM_REQ-1:0]            REQ_LAST;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic                          ARVALID;
    logic [ADDR_WIDTH-1:0]         ARADDR;
    logic                          RVALID;
    logic [DATA_WIDTH-1:0]         RDATA;
    logic [NUM_REQ-1:0]            RESP_VALID;
    logic [DATA_WIDTH-1:0]         RESP_DATA;
    logic [ID_WIDTH-1:0]           RESP_ID;
    logic                          BUSY;

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_LAST, RVALID, RDATA,
        output REQ_READY, ARVALID, ARADDR, RESP_VALID, RESP_DATA, RESP_ID, BUSY
    );

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_LAST, RVALID, RDATA,
        input  REQ_READY, ARVALID, ARADDR, RESP_VALID, RESP_DATA, RESP_ID, BUSY
    );
endinterface

// File: rtl/dpram_rd_arbiter.sv
// Round-robin arbiter sharing the dpram read port among NUM_REQ requesters,
// with bounded locked bursts and 1-cycle response routing back to the issuer.
module dpram_rd_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MAX_BURST  = 16
) (
    input logic                CLK,
    input logic                RESET,
    dpram_rd_arbiter_if.slave  bus
);
    localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ);
    localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]    owner_q, owner_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic [ID_WIDTH-1:0]    pend_id_q, pend_id_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

    logic [ADDR_WIDTH-1:0]  req_addr [NUM_REQ];
    logic                   rr_found;
    logic [ID_WIDTH-1:0]    rr_id;
    logic [ID_WIDTH-1:0]    gnt_id;
    logic [NUM_REQ-1:0]     ready_c;
    logic                   arvalid_c;
    logic [NUM_REQ-1:0]     resp_valid_c;

    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned off);
        return ID_WIDTH'((32'(base) + off) % NUM_REQ);
    endfunction

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_addr[i] = bus.REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Walk backwards so the first valid requester at or after ptr wins.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (bus.REQ_VALID[wrap_add(ptr_q, 32'(k))]) begin
                rr_found = 1'b1;
                rr_id    = wrap_add(ptr_q, 32'(k));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            pend_id_q <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
            addr_q    <= addr_d;
        end
    end

    // Grant, next-state and burst bookkeeping; a grant is always an accepted beat.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        pend_d    = 1'b0;
        pend_id_d = pend_id_q;
        addr_d    = addr_q;
        ready_c   = '0;
        arvalid_c = 1'b0;
        gnt_id    = '0;

        if (!RESET) begin
            case (state_q)
                IDLE: begin
                    gnt_id = rr_id;
                    if (rr_found) begin
                        ready_c[rr_id] = 1'b1;
                        arvalid_c      = 1'b1;
                    end
                end
                BURST: begin
                    gnt_id = owner_q;
                    if (bus.REQ_VALID[owner_q]) begin
                        ready_c[owner_q] = 1'b1;
                        arvalid_c        = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (arvalid_c) begin
            pend_d    = 1'b1;
            pend_id_d = gnt_id;
            addr_d    = req_addr[gnt_id];
            if (state_q == IDLE) begin
                if (bus.REQ_LAST[gnt_id] || MAX_BURST == 1) begin
                    ptr_d = wrap_add(gnt_id, 1);
                end else begin
                    state_d = BURST;
                    owner_d = gnt_id;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (bus.REQ_LAST[owner_q] || cnt_q == CNT_WIDTH'(MAX_BURST - 1)) begin
                    state_d = IDLE;
                    ptr_d   = wrap_add(owner_q, 1);
                end
            end
        end
    end

    // Responses are dropped while reset is high, including one already in flight.
    always_comb begin
        resp_valid_c = '0;
        if (!RESET && pend_q && bus.RVALID) begin
            resp_valid_c[pend_id_q] = 1'b1;
        end
    end

    assign bus.REQ_READY  = ready_c;
    assign bus.ARVALID    = arvalid_c;
    assign bus.ARADDR     = arvalid_c ? req_addr[gnt_id] : addr_q;
    assign bus.RESP_VALID = resp_valid_c;
    assign bus.RESP_DATA  = DATA_WIDTH'(bus.RDATA);
    assign bus.RESP_ID    = pend_id_q;
    assign bus.BUSY       = !RESET && ((state_q == BURST) || pend_q);

endmodule

// File: tb/tb_dpram_rd_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_dpram_rd_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;
    localparam int unsigned MB = 16;

    logic CLK = 1'b0;
    logic RESET;
    logic stray = 1'b0;
    logic ram_rv = 1'b0;

    always #5 CLK = ~CLK;

    dpram_rd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dpram_rd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    function automatic logic [63:0] memfn(input logic [AW-1:0] a);
        return {22'h2A5A5A, a, 22'h15A5A5, a};
    endfunction

    // dpram read port: one-cycle latency
    always @(posedge CLK) begin
        ram_rv   <= bus.ARVALID;
        bus.RDATA <= memfn(bus.ARADDR);
    end
    assign bus.RVALID = ram_rv | stray;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: lock owner (-1 = none), rotation start, beats in current lock, outstanding read
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    bit m_pend  = 0;
    int m_pend_id = 0;
    logic [AW-1:0] m_pend_addr = '0;
    int glog[$];

    always @(negedge CLK) begin
        int g;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rv;
        g = -1;
        if (!RESET) begin
            if (m_owner >= 0) begin
                if (bus.REQ_VALID[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < int'(N); k++) begin
                    if (g < 0 && bus.REQ_VALID[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
        end
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        e_rv = '0;
        if (!RESET && m_pend) e_rv[m_pend_id] = 1'b1;

        check("REQ_READY", 64'(bus.REQ_READY), 64'(e_ready));
        check("ARVALID", 64'(bus.ARVALID), 64'(g >= 0));
        if (g >= 0) check("ARADDR", 64'(bus.ARADDR), 64'(bus.REQ_ADDR[g*AW +: AW]));
        check("RESP_VALID", 64'(bus.RESP_VALID), 64'(e_rv));
        if (e_rv != '0) begin
            check("RESP_ID", 64'(bus.RESP_ID), 64'(m_pend_id));
            check("RESP_DATA", bus.RESP_DATA, memfn(m_pend_addr));
        end
        check("BUSY", 64'(bus.BUSY), 64'(!RESET && (m_owner >= 0 || m_pend)));

        if (RESET) begin
            m_owner = -1; m_ptr = 0; m_beats = 0; m_pend = 0; m_pend_id = 0;
        end else begin
            m_pend = (g >= 0);
            if (g >= 0) begin
                m_pend_id   = g;
                m_pend_addr = bus.REQ_ADDR[g*AW +: AW];
                glog.push_back(g);
                if (m_owner < 0) begin
                    if (bus.REQ_LAST[g] || MB == 1) m_ptr = (g + 1) % N;
                    else begin m_owner = g; m_beats = 1; end
                end else begin
                    m_beats++;
                    if (bus.REQ_LAST[g] || m_beats == int'(MB)) begin
                        m_owner = -1;
                        m_ptr   = (g + 1) % N;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        bus.REQ_ADDR[i*AW +: AW] = a;
    endtask

    task automatic check_log(input string name, input int exp[$]);
        check({name, "_len"}, 64'(glog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < glog.size()) check(name, 64'(glog[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        RESET = 1'b1;
        bus.REQ_VALID = '0;
        bus.REQ_LAST  = '0;
        bus.REQ_ADDR  = '0;
        step(2);
        RESET = 1'b0;

        // round-robin among four single-beat requesters
        glog.delete();
        bus.REQ_VALID = 4'b1111;
        bus.REQ_LAST  = 4'b1111;
        for (int i = 0; i < int'(N); i++) set_addr(i, AW'((i + 1) * 16));
        step(5);
        bus.REQ_VALID = '0;
        check_log("rr_order", '{0, 1, 2, 3, 0});
        step(2);

        // requester 2 locks for a 4-beat burst while requester 0 waits
        glog.delete();
        bus.REQ_LAST = 4'b0001;
        bus.REQ_VALID = 4'b0101;
        for (int b = 0; b < 4; b++) begin
            set_addr(2, AW'(32'h100 + b));
            bus.REQ_LAST[2] = (b == 3);
            step(1);
        end
        check("ptr_after_burst", 64'(m_ptr), 64'd3);
        bus.REQ_VALID[2] = 1'b0;
        step(1);
        bus.REQ_VALID = '0;
        check_log("burst4", '{2, 2, 2, 2, 0});
        step(2);

        // requester 1 never signals last: forced release after MAX_BURST beats
        glog.delete();
        bus.REQ_LAST  = 4'b1000;
        bus.REQ_VALID = 4'b1010;
        for (int b = 0; b < int'(MB) + 1; b++) begin
            set_addr(1, AW'(32'h200 + b));
            step(1);
        end
        bus.REQ_VALID = '0;
        check_log("max_burst", '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,3});
        step(2);

        // owner pauses mid-burst; the lock is held
        glog.delete();
        bus.REQ_LAST  = 4'b0001;
        bus.REQ_VALID = 4'b0100;
        step(1);
        bus.REQ_VALID = 4'b0101;
        step(1);
        bus.REQ_VALID = 4'b0001;
        step(1);
        #1;
        check("pause_arvalid", 64'(bus.ARVALID), 64'd0);
        check("pause_busy", 64'(bus.BUSY), 64'd1);
        check("pause_ready", 64'(bus.REQ_READY), 64'd0);
        step(2);
        bus.REQ_VALID = 4'b0101;
        bus.REQ_LAST[2] = 1'b1;
        step(1);
        bus.REQ_VALID = 4'b0001;
        step(1);
        bus.REQ_VALID = '0;
        check_log("pause", '{2, 2, 2, 0});
        step(2);

        // reset right after a mid-burst beat drops its response and the lock
        bus.REQ_LAST  = 4'b0000;
        bus.REQ_VALID = 4'b0010;
        step(2);
        RESET = 1'b1;
        bus.REQ_VALID = 4'b1111;
        bus.REQ_LAST  = 4'b1111;
        #1;
        check("rst_rvalid", 64'(bus.RVALID), 64'd1);
        check("rst_resp_valid", 64'(bus.RESP_VALID), 64'd0);
        check("rst_ready", 64'(bus.REQ_READY), 64'd0);
        step(1);
        RESET = 1'b0;
        glog.delete();
        #1;
        check("post_rst_ready", 64'(bus.REQ_READY), 64'b0001);
        step(1);
        bus.REQ_VALID = '0;
        check_log("post_rst", '{0});
        step(2);

        // stray read data with nothing outstanding
        stray = 1'b1;
        #1;
        check("stray_rvalid", 64'(bus.RVALID), 64'd1);
        check("stray_resp", 64'(bus.RESP_VALID), 64'd0);
        step(1);
        stray = 1'b0;
        step(1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            RESET = ($urandom_range(0, 99) == 0);
            bus.REQ_VALID = N'($urandom);
            for (int i = 0; i < int'(N); i++) begin
                bus.REQ_LAST[i] = ($urandom_range(0, 5) == 0);
                set_addr(i, AW'($urandom));
            end
            stray = ($urandom_range(0, 7) == 0);
            step(1);
        end
        RESET = 1'b0;
        stray = 1'b0;
        bus.REQ_VALID = '0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
